// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared constants and helpers for the fetch PC generator
package pc_gen_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam int PC_STEP = 4;

  function automatic logic is_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with push/pop/flush
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;

  logic          w_do_pop;
  logic          w_replace;
  logic          w_wr_en;
  logic [PW-1:0] w_ptr_inc;
  logic [PW-1:0] w_wr_idx;

  assign w_do_pop  = i_pop && (r_count != '0);
  // Pop and push together rewrite the current top in place; depth is unchanged.
  assign w_replace = i_push && w_do_pop;
  assign w_ptr_inc = r_ptr + 1'b1;
  assign w_wr_en   = !i_flush && i_push;
  assign w_wr_idx  = w_replace ? r_ptr : w_ptr_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (w_replace) begin
      r_count <= r_count;
    end else if (i_push) begin
      r_ptr <= w_ptr_inc;
      if (r_count != FULL) begin
        r_count <= r_count + 1'b1;
      end
    end else if (w_do_pop) begin
      r_ptr   <= r_ptr - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while the count is non-zero.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  assign o_top   = r_mem[r_ptr];
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program-counter generator with trap, redirect and RAS prediction
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 'h8000,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_pc,
  input  logic [XLEN-1:0] pred_target,
  input  logic            pred_call,
  input  logic            pred_ret,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_addr;

  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_fault_addr_nxt;
  logic            w_flush;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_push_data;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_run;

  assign w_run       = (r_state == ST_RUN);
  assign w_push_data = pred_pc + STEP;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_fault_addr_nxt = r_fault_addr;
    w_flush          = 1'b0;
    w_push           = 1'b0;
    w_pop            = 1'b0;
    if (trap_valid) begin
      w_pc_nxt    = trap_target & ALIGN_MASK;
      w_state_nxt = ST_RUN;
      w_flush     = 1'b1;
    end else if (redirect_valid && (r_state != ST_FAULT)) begin
      if (is_aligned(redirect_target[1:0])) begin
        w_pc_nxt    = redirect_target;
        w_state_nxt = ST_RUN;
      end else begin
        w_state_nxt      = ST_FAULT;
        w_fault_addr_nxt = redirect_target;
      end
    end else if (w_run && pred_valid && pred_ret && !w_ras_empty) begin
      w_pc_nxt = w_ras_top;
      w_pop    = 1'b1;
      w_push   = pred_call;
    end else if (w_run && pred_valid && !pred_ret && is_aligned(pred_target[1:0])) begin
      w_pc_nxt = pred_target;
      w_push   = pred_call;
    end else if (w_run && pc_ready) begin
      w_pc_nxt = r_pc + STEP;
    end else if (r_state == ST_BOOT) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_VECTOR;
      r_pc_valid   <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pc_valid   <= (w_state_nxt == ST_RUN);
      r_fault      <= (w_state_nxt == ST_FAULT);
      r_fault_addr <= w_fault_addr_nxt;
    end
  end

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty)
  );

  assign pc         = r_pc;
  assign pc_valid   = r_pc_valid;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic [31:0] pred_target;
  logic        pred_call;
  logic        pred_ret;
  logic        fault;
  logic [31:0] fault_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h8000),
    .RAS_DEPTH    (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .pc_ready        (pc_ready),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pred_valid      (pred_valid),
    .pred_pc         (pred_pc),
    .pred_target     (pred_target),
    .pred_call       (pred_call),
    .pred_ret        (pred_ret),
    .fault           (fault),
    .fault_addr      (fault_addr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clear_events();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    pred_valid = 1'b0; pred_call = 1'b0; pred_ret = 1'b0;
  endtask

  task automatic predict(input logic call, input logic ret, input logic [31:0] ppc, input logic [31:0] tgt);
    pred_valid = 1'b1; pred_call = call; pred_ret = ret;
    pred_pc = ppc; pred_target = tgt;
  endtask

  initial begin
    reset = 1'b1; pc_ready = 1'b1;
    trap_target = '0; redirect_target = '0; pred_pc = '0; pred_target = '0;
    clear_events();
    step(); step();
    check("rst_pc", pc, 32'h8000);
    check("rst_valid", {31'd0, pc_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);

    reset = 1'b0;
    #1;
    check("boot_valid", {31'd0, pc_valid}, 32'd0);
    step();
    check("boot_pc", pc, 32'h8000);
    check("boot_run_valid", {31'd0, pc_valid}, 32'd1);
    step(); check("seq1", pc, 32'h8004);
    step(); check("seq2", pc, 32'h8008);
    pc_ready = 1'b0;
    step(); check("hold", pc, 32'h8008);

    redirect_valid = 1'b1; redirect_target = 32'h9000;
    step(); check("redir_no_ready", pc, 32'h9000);
    trap_valid = 1'b1; trap_target = 32'h100;
    step(); check("trap_wins", pc, 32'h100);
    clear_events();

    redirect_valid = 1'b1; redirect_target = 32'h9002;
    step();
    check("fault_rise", {31'd0, fault}, 32'd1);
    check("fault_addr", fault_addr, 32'h9002);
    check("fault_valid", {31'd0, pc_valid}, 32'd0);
    check("fault_pc_hold", pc, 32'h100);
    redirect_target = 32'h9000;
    step();
    check("fault_redir_ignored", pc, 32'h100);
    check("fault_held", {31'd0, fault}, 32'd1);
    redirect_valid = 1'b0; trap_valid = 1'b1; trap_target = 32'h103;
    step();
    check("trap_exit_pc", pc, 32'h100);
    check("trap_exit_fault", {31'd0, fault}, 32'd0);
    check("trap_exit_valid", {31'd0, pc_valid}, 32'd1);
    clear_events();

    for (int i = 1; i <= 5; i++) begin
      predict(1'b1, 1'b0, 32'(i * 16), 32'h200);
      step(); check("call_pc", pc, 32'h200);
    end
    predict(1'b0, 1'b1, 32'h0, 32'h0);
    step(); check("ret1", pc, 32'h54);
    step(); check("ret2", pc, 32'h44);
    step(); check("ret3", pc, 32'h34);
    step(); check("ret4", pc, 32'h24);
    pc_ready = 1'b1;
    step(); check("ret5_seq", pc, 32'h28);
    pc_ready = 1'b0;

    predict(1'b1, 1'b0, 32'h10, 32'h300); step();
    predict(1'b1, 1'b0, 32'h20, 32'h300); step();
    check("call2_pc", pc, 32'h300);
    predict(1'b1, 1'b1, 32'h70, 32'h0);
    step(); check("callret_pc", pc, 32'h24);
    predict(1'b0, 1'b1, 32'h0, 32'h0);
    step(); check("callret_top", pc, 32'h74);
    step(); check("ret_after", pc, 32'h14);
    step(); check("ret_empty_hold", pc, 32'h14);
    predict(1'b0, 1'b0, 32'h0, 32'h302);
    step(); check("misaligned_pred", pc, 32'h14);
    clear_events();

    trap_valid = 1'b1; trap_target = 32'hFFFF_FFFC;
    step(); check("trap_top", pc, 32'hFFFF_FFFC);
    trap_valid = 1'b0; pc_ready = 1'b1;
    step(); check("wrap_seq", pc, 32'h0);
    pc_ready = 1'b0;
    predict(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h400);
    step(); check("wrap_call", pc, 32'h400);
    predict(1'b0, 1'b1, 32'h0, 32'h0);
    step(); check("wrap_ret", pc, 32'h0);
    clear_events();

    reset = 1'b1;
    #1;
    check("async_rst_pc", pc, 32'h8000);
    check("async_rst_valid", {31'd0, pc_valid}, 32'd0);
    step();
    redirect_valid = 1'b1; redirect_target = 32'hA000;
    reset = 1'b0;
    step();
    check("boot_redir_pc", pc, 32'hA000);
    check("boot_redir_valid", {31'd0, pc_valid}, 32'd1);
    clear_events();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
